// File: rtl/i2c_target_stretch.sv
// I2C write-only target front-end: START/STOP detect, address match/ACK, byte receive with SCL stretch
// until the local sink accepts. Optional stretch timeout enabled by defining I2C_TGT_TIMEOUT_EN.
module i2c_target_stretch #(
    parameter logic [6:0]  TGT_ADDR    = 7'h42,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned STRETCH_MAX = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_first,
    output logic       busy,
    output logic       overrun
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ADDR     = 3'd1;
    localparam logic [2:0] ADDR_ACK = 3'd2;
    localparam logic [2:0] DATA     = 3'd3;
    localparam logic [2:0] STRETCH  = 3'd4;
    localparam logic [2:0] DATA_ACK = 3'd5;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic       scl_prev, sda_prev;
    logic       scl_s, sda_s;
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [2:0] state;
    logic [2:0] bitcnt;
    logic       byte_full;
    logic       first_armed;
    logic [7:0] shreg;

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    // Synchronisers start at the idle-bus level so reset never fabricates an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_prev <= scl_s;
            sda_prev <= sda_s;
        end
    end

    assign scl_rise  = scl_s & ~scl_prev;
    assign scl_fall  = ~scl_s & scl_prev & ~scl_oe;
    assign start_det = scl_s & scl_prev & sda_prev & ~sda_s;
    assign stop_det  = scl_s & scl_prev & ~sda_prev & sda_s;

`ifdef I2C_TGT_TIMEOUT_EN
    logic [14:0] to_cnt;
    logic        to_hit;

    always_ff @(posedge clk) begin
        if (rst || state != STRETCH) begin
            to_cnt <= '0;
        end else if (!to_hit) begin
            to_cnt <= to_cnt + 15'd1;
        end
    end

    assign to_hit = (to_cnt == 15'(STRETCH_MAX - 1));
`else
    logic [31:0] unused_stretch_max;
    assign unused_stretch_max = 32'(STRETCH_MAX);
    assign overrun = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bitcnt      <= '0;
            byte_full   <= 1'b0;
            first_armed <= 1'b0;
            shreg       <= '0;
            scl_oe      <= 1'b0;
            sda_oe      <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_first    <= 1'b0;
            busy        <= 1'b0;
`ifdef I2C_TGT_TIMEOUT_EN
            overrun     <= 1'b0;
`endif
        end else begin
`ifdef I2C_TGT_TIMEOUT_EN
            overrun <= 1'b0;
`endif
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
                rx_first <= 1'b0;
            end
            // A pending byte survives START/STOP; only the bus-side state is discarded
            if (start_det || stop_det) begin
                state       <= start_det ? ADDR : IDLE;
                bitcnt      <= '0;
                byte_full   <= 1'b0;
                first_armed <= 1'b0;
                scl_oe      <= 1'b0;
                sda_oe      <= 1'b0;
                busy        <= 1'b0;
            end else begin
                case (state)
                    IDLE: ;
                    ADDR, DATA: begin
                        if (scl_rise) begin
                            shreg  <= {shreg[6:0], sda_s};
                            bitcnt <= bitcnt + 3'd1;
                            if (bitcnt == 3'd7) byte_full <= 1'b1;
                        end else if (scl_fall && byte_full) begin
                            byte_full <= 1'b0;
                            if (state == ADDR) begin
                                if (shreg[7:1] == TGT_ADDR && !shreg[0]) begin
                                    sda_oe <= 1'b1;
                                    state  <= ADDR_ACK;
                                end else begin
                                    state <= IDLE;
                                end
                            end else begin
                                scl_oe      <= 1'b1;
                                sda_oe      <= 1'b1;
                                rx_data     <= shreg;
                                rx_valid    <= 1'b1;
                                rx_first    <= first_armed;
                                first_armed <= 1'b0;
                                state       <= STRETCH;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            sda_oe      <= 1'b0;
                            busy        <= 1'b1;
                            first_armed <= 1'b1;
                            state       <= DATA;
                        end
                    end
                    STRETCH: begin
                        // rx_valid low here means the handshake happened last cycle; ACK is already on SDA
                        if (!rx_valid) begin
                            scl_oe <= 1'b0;
                            state  <= DATA_ACK;
                        end
`ifdef I2C_TGT_TIMEOUT_EN
                        else if (!rx_ready && to_hit) begin
                            rx_valid <= 1'b0;
                            rx_first <= 1'b0;
                            overrun  <= 1'b1;
                            scl_oe   <= 1'b0;
                            sda_oe   <= 1'b0;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end
`endif
                    end
                    DATA_ACK: begin
                        if (scl_fall) begin
                            sda_oe <= 1'b0;
                            state  <= DATA;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
